// File: rtl/ps2_dev_pkg.sv
// =============================================================================
// ps2_dev_pkg : shared types and helpers for the PS/2 device-side transmitter
// Revision    : 1.0
// =============================================================================
`default_nettype none

package ps2_dev_pkg;

    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BIT_HI  = 3'd1,
        ST_BIT_LO  = 3'd2,
        ST_GAP     = 3'd3,
        ST_INHIBIT = 3'd4
    } ps2_dev_state_e;

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    // Bit 0 goes on the wire first: start, data LSB-first, parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b, input logic par);
        return {1'b1, par, b, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_dev_fifo.sv
// =============================================================================
// ps2_dev_fifo : synchronous byte FIFO; push while full is dropped
// Revision     : 1.0
// =============================================================================
`default_nettype none

module ps2_dev_fifo
    import ps2_dev_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               head_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_dev_tx.sv
// =============================================================================
// ps2_dev_tx : PS/2 device transmitter with FIFO, host-inhibit abort/retry.
//              Optional parity error injection: PS2_DEV_TX_ERRINJ_EN.
// Revision   : 1.0
// =============================================================================
`default_nettype none

module ps2_dev_tx
    import ps2_dev_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int HALF_CYC    = 30,
    parameter int GAP_CYC     = 60,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    input  logic [7:0]                        wr_data_i,
`ifdef PS2_DEV_TX_ERRINJ_EN
    input  logic                              errinj_i,
`endif
    input  logic                              ps2_clk_i,
    output logic                              ps2_clk_o,
    output logic                              ps2_dat_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
    output logic                              abort_o
);

    localparam int HCNT_W = $clog2(HALF_CYC);
    localparam int GCNT_W = $clog2(GAP_CYC + 1);
    localparam logic [HCNT_W-1:0] HALF_LAST = HCNT_W'(HALF_CYC - 1);
    localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(GAP_CYC - 1);
    localparam logic [3:0]        LAST_IDX  = 4'(FRAME_BITS - 1);

    ps2_dev_state_e          state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [HCNT_W-1:0]       hcnt_q;
    logic [GCNT_W-1:0]       gcnt_q;
    logic [3:0]              idx_q;
    logic [FRAME_BITS-1:0]   frame_q;
    logic                    clk_q;
    logic                    dat_q;
    logic                    abort_q;

    logic                    w_clk_s;
    logic                    w_empty;
    logic                    w_full;
    logic [7:0]              w_head;
    logic                    w_par;
    logic                    w_half_done;
    logic                    w_inhibit;
    logic                    w_pop;

    ps2_dev_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wr_valid_i),
        .data_i  (wr_data_i),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ps2_clk_i};
        end
    end

    assign w_clk_s = sync_q[SYNC_STAGES-1];

`ifdef PS2_DEV_TX_ERRINJ_EN
    assign w_par = odd_par(w_head) ^ errinj_i;
`else
    assign w_par = odd_par(w_head);
`endif

    // Host inhibit only counts while our own clock output is released high.
    assign w_inhibit   = !w_clk_s && clk_q;
    assign w_half_done = (hcnt_q == HALF_LAST);
    assign w_pop       = (state_q == ST_BIT_LO) && w_half_done && (idx_q == LAST_IDX);

    assign wr_ready_o = !w_full;
    assign busy_o     = (state_q != ST_IDLE);
    assign ps2_clk_o  = clk_q;
    assign ps2_dat_o  = dat_q;
    assign abort_o    = abort_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            gcnt_q  <= '0;
            idx_q   <= '0;
            frame_q <= '1;
            clk_q   <= 1'b1;
            dat_q   <= 1'b1;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    clk_q <= 1'b1;
                    dat_q <= 1'b1;
                    if (!w_empty && w_clk_s) begin
                        frame_q <= build_frame(w_head, w_par);
                        idx_q   <= '0;
                        hcnt_q  <= '0;
                        state_q <= ST_BIT_HI;
                    end
                end
                ST_BIT_HI: begin
                    if (w_inhibit) begin
                        clk_q   <= 1'b1;
                        dat_q   <= 1'b1;
                        abort_q <= 1'b1;
                        hcnt_q  <= '0;
                        state_q <= ST_INHIBIT;
                    end else begin
                        clk_q <= 1'b1;
                        dat_q <= frame_q[idx_q];
                        if (w_half_done) begin
                            hcnt_q  <= '0;
                            state_q <= ST_BIT_LO;
                        end else begin
                            hcnt_q <= hcnt_q + 1'b1;
                        end
                    end
                end
                ST_BIT_LO: begin
                    clk_q <= 1'b0;
                    if (w_half_done) begin
                        hcnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            gcnt_q  <= '0;
                            state_q <= ST_GAP;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= ST_BIT_HI;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    clk_q <= 1'b1;
                    dat_q <= 1'b1;
                    if (gcnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gcnt_q <= gcnt_q + 1'b1;
                    end
                end
                ST_INHIBIT: begin
                    clk_q <= 1'b1;
                    dat_q <= 1'b1;
                    if (w_clk_s) begin
                        gcnt_q  <= '0;
                        state_q <= ST_GAP;
                    end
                end
                default: begin
                    clk_q   <= 1'b1;
                    dat_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_dev_tx.sv
// =============================================================================
// tb_ps2_dev_tx : directed scoreboard bench for ps2_dev_tx
// Revision      : 1.0
// =============================================================================
`default_nettype none

module tb_ps2_dev_tx;

    localparam int HALF_CYC    = 4;
    localparam int GAP_CYC     = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LW          = $clog2(FIFO_DEPTH + 1);
    localparam int FRAME_CYC   = 22 * HALF_CYC;
`ifdef PS2_DEV_TX_ERRINJ_EN
    localparam bit ERRINJ = 1'b1;
`else
    localparam bit ERRINJ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          ps2_clk_in = 1'b1;
    logic          errinj = 1'b0;
    logic          wr_ready_o;
    logic          ps2_clk_o;
    logic          ps2_dat_o;
    logic          busy_o;
    logic [LW-1:0] level_o;
    logic          abort_o;
    logic          inj_eff;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [10:0] sb [$];

    ps2_dev_tx #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HALF_CYC    (HALF_CYC),
        .GAP_CYC     (GAP_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready_o),
        .wr_data_i  (wr_data),
`ifdef PS2_DEV_TX_ERRINJ_EN
        .errinj_i   (errinj),
`endif
        .ps2_clk_i  (ps2_clk_in),
        .ps2_clk_o  (ps2_clk_o),
        .ps2_dat_o  (ps2_dat_o),
        .busy_o     (busy_o),
        .level_o    (level_o),
        .abort_o    (abort_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign inj_eff = ERRINJ & errinj;

    // Independent frame model: parity from a population count.
    function automatic logic [10:0] model_frame(input logic [7:0] b, input logic inj);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = ((ones % 2) == 0) ^ inj;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        logic acc;
        wr_valid = 1'b1;
        wr_data  = b;
        acc      = wr_ready_o;
        @(negedge clk);
        wr_valid = 1'b0;
        check("push_accept", 32'(acc), 32'd1);
        if (acc) sb.push_back(model_frame(b, inj_eff));
    endtask

    // Starts sampling at the current negedge; idle = cycles seen before the start bit.
    task automatic recv(output logic [10:0] bits, output int idle, output bit tok, output int lastc);
        bit found;
        bits  = '1;
        idle  = 0;
        tok   = 1'b1;
        lastc = 0;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (ps2_dat_o === 1'b0) found = 1'b1;
            else begin
                idle++;
                @(negedge clk);
            end
        end
        if (!found) begin
            check("start_timeout", 32'd0, 32'd1);
            tok = 1'b0;
        end else begin
            for (int i = 0; i < FRAME_CYC; i++) begin
                if (i % (2 * HALF_CYC) == 0) bits[i / (2 * HALF_CYC)] = ps2_dat_o;
                else if (ps2_dat_o !== bits[i / (2 * HALF_CYC)]) tok = 1'b0;
                if (ps2_clk_o !== ((i % (2 * HALF_CYC)) < HALF_CYC)) tok = 1'b0;
                lastc = cyc;
                @(negedge clk);
            end
        end
    endtask

    task automatic expect_frame(input string tag, input logic [10:0] bits);
        logic [10:0] exp;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check(tag, 32'(bits), 32'(exp));
        end
    endtask

    logic [10:0] bits;
    int          idl;
    bit          tok;
    int          lc;
    logic [10:0] got [6];
    logic [7:0]  bytes6 [6];
    int          acc_edge [6];
    int          first_last;
    int          k4;
    logic        acc4;
    bit          tok_all;
    int          idl4;
    bit          tk4;
    int          lc4;
    int          rises;
    logic        prevc;
    bit          seen;

    initial begin
        bytes6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Reset
        repeat (3) @(negedge clk);
        check("rst_clk", 32'(ps2_clk_o), 32'd1);
        check("rst_dat", 32'(ps2_dat_o), 32'd1);
        check("rst_ready", 32'(wr_ready_o), 32'd1);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_abort", 32'(abort_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x1C
        push(8'h1C);
        recv(bits, idl, tok, lc);
        check("t2_latency", 32'(idl), 32'd2);
        check("t2_timing", 32'(tok), 32'd1);
        check("t2_literal", 32'(bits), 32'h438);
        expect_frame("t2_frame", bits);
        check("t2_level", 32'(level_o), 32'd0);
        repeat (GAP_CYC + 2) @(negedge clk);
        check("t2_idle", 32'(busy_o), 32'd0);

        // Back-to-back 0xF0, 0x1C: one gap plus the load cycle between frames
        push(8'hF0);
        push(8'h1C);
        recv(bits, idl, tok, lc);
        check("t3_f0_parity", 32'(bits[9]), 32'd1);
        expect_frame("t3_frame_f0", bits);
        recv(bits, idl, tok, lc);
        check("t3_gap", 32'(idl), 32'(GAP_CYC + 1));
        check("t3_timing", 32'(tok), 32'd1);
        expect_frame("t3_frame_1c", bits);
        repeat (GAP_CYC + 2) @(negedge clk);

        // Six bytes with valid held against a 4-deep FIFO
        tok_all = 1'b1;
        first_last = 0;
        k4 = 0;
        fork
            begin
                for (int n = 0; n < 2000 && k4 < 6; n++) begin
                    wr_valid = 1'b1;
                    wr_data  = bytes6[k4];
                    acc4     = wr_ready_o;
                    @(negedge clk);
                    if (acc4) begin
                        sb.push_back(model_frame(bytes6[k4], inj_eff));
                        acc_edge[k4] = cyc;
                        k4++;
                        if (k4 == 4) check("t4_full_after_4", 32'(wr_ready_o), 32'd0);
                    end
                end
                wr_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 6; f++) begin
                    recv(got[f], idl4, tk4, lc4);
                    if (f == 0) first_last = lc4;
                    tok_all &= tk4;
                end
            end
        join
        check("t4_all_accepted", 32'(k4), 32'd6);
        if (k4 == 6) check("t4_fifth_after_pop", 32'(acc_edge[4]), 32'(first_last + 1));
        check("t4_timing", 32'(tok_all), 32'd1);
        for (int f = 0; f < 6; f++) expect_frame("t4_frame", got[f]);
        repeat (GAP_CYC + 2) @(negedge clk);

        // Host inhibit during bit 5 high phase, then retry
        push(8'h6B);
        rises = 0;
        prevc = ps2_clk_o;
        for (int n = 0; n < 400 && rises < 5; n++) begin
            @(negedge clk);
            if (prevc === 1'b0 && ps2_clk_o === 1'b1) rises++;
            prevc = ps2_clk_o;
        end
        check("t5_bit5_reached", 32'(rises), 32'd5);
        ps2_clk_in = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (abort_o === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("t5_abort_seen", 32'(seen), 32'd1);
        check("t5_lines_released", 32'({ps2_clk_o, ps2_dat_o}), 32'd3);
        check("t5_level_kept", 32'(level_o), 32'd1);
        @(negedge clk);
        check("t5_abort_one_pulse", 32'(abort_o), 32'd0);
        repeat (20) @(negedge clk);
        check("t5_inhibit_hold", 32'({ps2_clk_o, ps2_dat_o, busy_o}), 32'd7);
        ps2_clk_in = 1'b1;
        recv(bits, idl, tok, lc);
        // sync delay + inhibit exit + gap + load + first high cycle of start bit
        check("t5_retry_latency", 32'(idl), 32'(SYNC_STAGES + GAP_CYC + 3));
        check("t5_timing", 32'(tok), 32'd1);
        expect_frame("t5_retry_frame", bits);
        repeat (GAP_CYC + 2) @(negedge clk);
        check("t5_level_end", 32'(level_o), 32'd0);

        // Reset mid-frame
        push(8'h1C);
        repeat (40) @(negedge clk);
        check("t6_midframe", 32'({busy_o, ps2_clk_o & ps2_dat_o}), 32'({1'b1, ps2_clk_o & ps2_dat_o}) | 32'h2);
        rst = 1'b1;
        @(negedge clk);
        check("t6_lines", 32'({ps2_clk_o, ps2_dat_o}), 32'd3);
        check("t6_level", 32'(level_o), 32'd0);
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_ready", 32'(wr_ready_o), 32'd1);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);

`ifdef PS2_DEV_TX_ERRINJ_EN
        errinj = 1'b1;
        push(8'h1C);
        errinj = 1'b0;
        recv(bits, idl, tok, lc);
        check("t6_errinj_parity", 32'(bits[9]), 32'd1);
        expect_frame("t6_errinj_frame", bits);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
